series_engine_arbiter: RTL and testbench
========================================

// Module: series_engine_arbiter
// PURPOSE
//  Shares one series-evaluation engine (x -> r, start/done controller + datapath) among NREQ requesters.
//  Round-robin pick of one pending request; launches the engine with the winner's x and waits for completion.
//  Returns the result to that requester over a valid/ready response channel.
//  Sits between the client blocks and the engine's start/x/done/result pins; one job outstanding at a time.
// PARAMETERS
//  NREQ     4    number of requesters (>=2)
//  XW       16   operand x width
//  RW       16   result width
//  WD_CYC   8    watchdog: max cycles waiting for eng_done to drop after launch
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        asynchronous, active-high reset
//  req_valid    in   NREQ     per-requester request pending
//  req_x        in   NREQ*XW  per-requester operand, slice i = [i*XW +: XW]
//  req_ready    out  NREQ     one-hot, 1-cycle accept pulse
//  resp_valid   out  NREQ     one-hot, response for requester i
//  resp_result  out  RW       shared result bus, valid when any resp_valid
//  resp_err     out  1        response is a watchdog error (result = 0)
//  resp_ready   in   NREQ     per-requester response accept
//  eng_start    out  1        engine start, exactly 1-cycle pulse per job
//  eng_x        out  XW       engine operand, stable from LAUNCH to end of WAIT_DONE
//  eng_done     in   1        engine idle/done level (1 while engine idle)
//  eng_result   in   RW       engine result, sampled when eng_done returns to 1
//  busy         out  1        1 in every state except IDLE
// BEHAVIOUR
//  Reset (async): state=IDLE, rr_ptr=0, all outputs 0, latched x/id/result/err = 0; engine is reset separately.
//  States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, RESP.
//  IDLE: if |req_valid && eng_done: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NREQ;
//   req_ready[winner]=1 this cycle; latch x_q=req_x[winner], id_q=winner; rr_ptr <= (winner+1) mod NREQ; -> LAUNCH.
//   Else stay in IDLE (eng_done==0 blocks accept).
//  LAUNCH: eng_start=1, eng_x=x_q; wd_cnt<=0; -> WAIT_BUSY.
//  WAIT_BUSY: eng_start=0; eng_done==0 -> WAIT_DONE; else wd_cnt++; wd_cnt==WD_CYC-1 -> RESP with err_q=1, res_q=0.
//  WAIT_DONE: no timeout; eng_done==1 -> res_q<=eng_result, err_q<=0, -> RESP.
//  RESP: resp_valid[id_q]=1, resp_result=res_q, resp_err=err_q; resp_ready[id_q]==1 -> IDLE.
//   resp_ready of other requesters ignored; resp_valid/result held until accepted.
//  Latency (no contention): accept T; eng_start T+1; earliest resp_valid = cycle after engine done rises.
//  Back-to-back: next accept no earlier than the cycle after the RESP handshake.
//  Requesters hold req_valid/req_x until req_ready; deassertion before accept simply drops out of arbitration.
//  Simultaneous requests: strict rotation from rr_ptr; no requester starves (bounded by NREQ-1 jobs).
//  rr_ptr wraps NREQ-1 -> 0. Outputs are registered or decoded from state only (no comb path req->eng).
//  rst mid-job: immediate return to IDLE, job dropped, no response issued.
// STRUCTURE
//  Package series_arb_pkg: state enum (arb_state_t), default NREQ/XW/RW, ID_W=$clog2(NREQ).
//  Sub-module rr_picker: combinational (req_valid, rr_ptr) -> (any, winner id, one-hot grant).
//  Top holds FSM, rr_ptr, x_q/id_q/res_q/err_q, wd_cnt.
// TESTING (behavioural engine model: done drops 1 cycle after start, rises 12 cycles later, result = x+1)
//  Single req: req_valid[2]=1, x=5 -> req_ready[2] 1 cycle, eng_start 1 cycle with eng_x=5, resp_valid[2], result=6, err=0.
//  All 4 valid continuously after reset -> grant order 0,1,2,3,0; each result = its x+1 on resp_valid[id].
//  rr_ptr=3, reqs 1 and 3 valid -> 3 served first, then 1; ptr wrap checked.
//  Engine never drops done -> after WD_CYC=8 cycles in WAIT_BUSY, resp_valid[id]=1, resp_err=1, result=0.
//  resp_ready held 0 for 5 cycles -> resp_valid/result stable, no new eng_start; accept -> IDLE next cycle.
//  rst pulse during WAIT_DONE -> all outputs 0 immediately, busy=0, no response; next req served from ptr 0.

Source files
------------

// File: rtl/series_arb_pkg.sv
// Shared types and default sizing for the series-engine arbiter.
package series_arb_pkg;

  localparam int unsigned DEF_NREQ   = 4;
  localparam int unsigned DEF_XW     = 16;
  localparam int unsigned DEF_RW     = 16;
  localparam int unsigned DEF_WD_CYC = 8;
  localparam int unsigned ID_W       = $clog2(DEF_NREQ);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } arb_state_t;

  // Next round-robin position after id, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/series_engine_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending requester at or after the pointer.
module rr_picker
  import series_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned PID_W  = ID_W
) (
  input  logic [NREQ-1:0]  i_req_valid,
  input  logic [PID_W-1:0] i_rr_ptr,
  output logic             o_any_c,
  output logic [PID_W-1:0] o_winner_c,
  output logic [NREQ-1:0]  o_grant_c
);

  int unsigned w_idx;

  assign o_any_c = |i_req_valid;

  // Scan from farthest to nearest offset so the nearest pending request wins.
  always_comb begin
    w_idx      = 0;
    o_winner_c = '0;
    o_grant_c  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      w_idx = 32'(i_rr_ptr) + unsigned'(k);
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (i_req_valid[PID_W'(w_idx)]) o_winner_c = PID_W'(w_idx);
    end
    o_grant_c[o_winner_c] = o_any_c;
  end

endmodule

// File: rtl/series_engine_arbiter.sv
// Shares one series-evaluation engine among NREQ requesters, one job at a time.
module series_engine_arbiter
  import series_arb_pkg::*;
#(
  parameter int unsigned NREQ   = DEF_NREQ,
  parameter int unsigned XW     = DEF_XW,
  parameter int unsigned RW     = DEF_RW,
  parameter int unsigned WD_CYC = DEF_WD_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*XW-1:0]   req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [RW-1:0]        resp_result,
  output logic                 resp_err,
  input  logic [NREQ-1:0]      resp_ready,
  output logic                 eng_start,
  output logic [XW-1:0]        eng_x,
  input  logic                 eng_done,
  input  logic [RW-1:0]        eng_result,
  output logic                 busy
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WDW = $clog2(WD_CYC + 1);

  arb_state_t       r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id_q;
  logic [XW-1:0]    r_x_q;
  logic [RW-1:0]    r_res_q;
  logic             r_err_q;
  logic [WDW-1:0]   r_wd_cnt;
  logic             r_eng_start;
  logic             r_busy;
  logic [NREQ-1:0]  r_resp_valid;

  logic             w_any;
  logic [IDW-1:0]   w_winner;
  logic [NREQ-1:0]  w_grant;
  logic             w_accept;
  logic [XW-1:0]    w_sel_x;

  rr_picker #(
    .NREQ  (NREQ),
    .PID_W (IDW)
  ) u_picker (
    .i_req_valid (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_any_c     (w_any),
    .o_winner_c  (w_winner),
    .o_grant_c   (w_grant)
  );

  // Accept only from IDLE while the engine reports idle.
  assign w_accept = (r_state == ST_IDLE) && w_any && eng_done;

  // Select the winner's operand slice.
  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (w_winner == IDW'(i)) w_sel_x = req_x[i*XW +: XW];
    end
  end

  assign req_ready   = w_accept ? w_grant : '0;
  assign resp_valid  = r_resp_valid;
  assign resp_result = r_res_q;
  assign resp_err    = r_err_q;
  assign eng_start   = r_eng_start;
  assign eng_x       = r_x_q;
  assign busy        = r_busy;

  // Job controller: accept, launch, watch engine, hold response until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= '0;
      r_id_q       <= '0;
      r_x_q        <= '0;
      r_res_q      <= '0;
      r_err_q      <= 1'b0;
      r_wd_cnt     <= '0;
      r_eng_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_resp_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_x_q       <= w_sel_x;
            r_id_q      <= w_winner;
            r_rr_ptr    <= IDW'(rr_next(32'(w_winner), NREQ));
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          r_eng_start <= 1'b0;
          r_wd_cnt    <= '0;
          r_state     <= ST_WAIT_BUSY;
        end
        ST_WAIT_BUSY: begin
          if (!eng_done) begin
            r_state <= ST_WAIT_DONE;
          end else if (r_wd_cnt == WDW'(WD_CYC - 1)) begin
            r_res_q      <= '0;
            r_err_q      <= 1'b1;
            r_resp_valid <= NREQ'(1) << r_id_q;
            r_state      <= ST_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + WDW'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (eng_done) begin
            r_res_q      <= eng_result;
            r_err_q      <= 1'b0;
            r_resp_valid <= NREQ'(1) << r_id_q;
            r_state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (resp_ready[r_id_q]) begin
            r_resp_valid <= '0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_eng_start  <= 1'b0;
          r_busy       <= 1'b0;
          r_resp_valid <= '0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_engine_arbiter.sv
// Scoreboard bench for series_engine_arbiter with a behavioural engine model.
module tb_series_engine_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned XW      = 16;
  localparam int unsigned RW      = 16;
  localparam int unsigned WD_CYC  = 8;
  localparam int unsigned ENG_LAT = 12;
  localparam int unsigned TID_W   = $clog2(NREQ);

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*XW-1:0]  req_x;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     resp_valid;
  logic [RW-1:0]       resp_result;
  logic                resp_err;
  logic [NREQ-1:0]     resp_ready;
  logic                eng_start;
  logic [XW-1:0]       eng_x;
  logic                eng_done;
  logic [RW-1:0]       eng_result;
  logic                busy;

  always #5 clk = ~clk;

  series_engine_arbiter #(
    .NREQ(NREQ), .XW(XW), .RW(RW), .WD_CYC(WD_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_err(resp_err),
    .resp_ready(resp_ready),
    .eng_start(eng_start), .eng_x(eng_x), .eng_done(eng_done), .eng_result(eng_result),
    .busy(busy)
  );

  typedef struct { int unsigned id; logic [XW-1:0] x; } job_t;
  typedef struct { int unsigned id; logic err; logic [RW-1:0] res; } exp_t;

  job_t        job_q[$];
  exp_t        exp_q[$];
  int unsigned rid_q[$];
  logic [XW-1:0] lx_q[$];

  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  int unsigned stall = 0;
  logic        eng_dead = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int unsigned w);
    return NREQ'(1) << w;
  endfunction

  // Reference arbitration: nearest pending requester at or after p, modulo NREQ.
  function automatic int unsigned model_pick(input logic [NREQ-1:0] v, input int unsigned p);
    int unsigned idx;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (p + unsigned'(k)) % NREQ;
      if (v[TID_W'(idx)]) return idx;
    end
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine: done drops the cycle after start, returns ENG_LAT cycles later with x+1.
  initial begin
    logic          st;
    logic [XW-1:0] xs;
    int unsigned   cnt;
    eng_done = 1'b1;
    eng_result = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      st = eng_start && !eng_dead;
      xs = eng_x;
      @(posedge clk);
      #1;
      if (rst) begin
        eng_done = 1'b1;
        cnt = 0;
      end else if (st) begin
        eng_done = 1'b0;
        cnt = ENG_LAT;
        eng_result = RW'(xs) + RW'(1);
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) eng_done = 1'b1;
      end
    end
  end

  // Monitor: arbitration order, launch, and response scoreboard.
  initial begin
    int unsigned   mptr, w, id, start_cyc, acc_cyc;
    logic [XW-1:0] cur_x;
    logic          prev_start, prev_done, prev_hs, hs, in_job, resp_first, found;
    exp_t          e;
    int            k;
    mptr = 0; start_cyc = 0; acc_cyc = 0; cur_x = '0;
    prev_start = 0; prev_done = 1; prev_hs = 0; in_job = 0; resp_first = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mptr = 0; rid_q.delete(); lx_q.delete();
        prev_start = 0; prev_done = 1; prev_hs = 0; in_job = 0; resp_first = 0;
      end else begin
        hs = 0;
        if (!busy && eng_done && req_valid != '0) begin
          w = model_pick(req_valid, mptr);
          chk("grant", 64'(req_ready), 64'(onehot(w)));
          mptr = (w + 1) % NREQ;
          rid_q.push_back(w);
          lx_q.push_back(req_x[w*XW +: XW]);
          acc_cyc = cyc;
        end else if (req_ready != '0) begin
          chk("spurious_grant", 64'(req_ready), 64'(0));
        end
        if (eng_start) begin
          chk("start_pulse", 64'(prev_start), 64'(0));
          if (lx_q.size() == 0) begin
            chk("start_unexpected", 64'(eng_start), 64'(0));
          end else begin
            cur_x = lx_q.pop_front();
            chk("eng_x", 64'(eng_x), 64'(cur_x));
            chk("start_latency", 64'(cyc - acc_cyc), 64'(1));
            start_cyc = cyc; in_job = 1; resp_first = 1;
          end
        end
        prev_start = eng_start;
        if (in_job && eng_done && !prev_done) chk("eng_x_hold", 64'(eng_x), 64'(cur_x));
        prev_done = eng_done;
        if (resp_valid != '0) begin
          chk("no_start_in_resp", 64'(eng_start), 64'(0));
          if (rid_q.size() == 0) begin
            chk("resp_unexpected", 64'(resp_valid), 64'(0));
          end else begin
            id = rid_q[0];
            chk("resp_valid", 64'(resp_valid), 64'(onehot(id)));
            found = 0; k = -1;
            for (int j = 0; j < exp_q.size(); j++) begin
              if (!found && exp_q[j].id == id) begin found = 1; k = j; end
            end
            if (!found) begin
              chk("resp_noexp", 64'(resp_valid), 64'(0));
            end else begin
              e = exp_q[k];
              chk("resp_result", 64'(resp_result), 64'(e.res));
              chk("resp_err", 64'(resp_err), 64'(e.err));
              if (resp_first) begin
                chk("resp_latency", 64'(cyc - start_cyc),
                    64'(e.err ? WD_CYC + 1 : ENG_LAT + 2));
                resp_first = 0; in_job = 0;
              end
              if (resp_ready[TID_W'(id)]) begin
                void'(rid_q.pop_front());
                exp_q.delete(k);
                hs = 1;
              end
            end
          end
        end
        if (prev_hs) chk("idle_after_hs", 64'(busy), 64'(0));
        prev_hs = hs;
      end
    end
  end

  task automatic issue(input int unsigned id, input logic [XW-1:0] x);
    job_t j;
    exp_t e;
    j.id = id; j.x = x;
    job_q.push_back(j);
    e.id = id; e.err = eng_dead;
    e.res = eng_dead ? RW'(0) : RW'(x) + RW'(1);
    exp_q.push_back(e);
  endtask

  // One requester-side cycle: retire accepted requests, apply response policy, present jobs.
  task automatic step();
    logic [NREQ-1:0] acc, rv;
    logic            placed;
    @(negedge clk);
    acc = req_ready;
    rv  = resp_valid;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~acc;
    if (stall > 0 && rv != '0) stall--;
    if (stall > 0) resp_ready = (rv != '0) ? ~rv : '0;
    else           resp_ready = '1;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (!req_valid[i]) begin
        placed = 0;
        for (int j = 0; j < job_q.size(); j++) begin
          if (!placed && job_q[j].id == unsigned'(i)) begin
            req_valid[i] = 1'b1;
            req_x[i*XW +: XW] = job_q[j].x;
            job_q.delete(j);
            placed = 1;
          end
        end
      end
    end
  endtask

  task automatic drain(input int unsigned budget, input string name);
    int unsigned n;
    n = 0;
    while ((exp_q.size() != 0 || job_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    job_q.delete();
    repeat (2) step();
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ready"},   64'(req_ready),   64'(0));
    chk({tag, "_resp_valid"},  64'(resp_valid),  64'(0));
    chk({tag, "_resp_result"}, 64'(resp_result), 64'(0));
    chk({tag, "_resp_err"},    64'(resp_err),    64'(0));
    chk({tag, "_eng_start"},   64'(eng_start),   64'(0));
    chk({tag, "_eng_x"},       64'(eng_x),       64'(0));
    chk({tag, "_busy"},        64'(busy),        64'(0));
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = '0;
    stall = 0;
    job_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int unsigned n;
    rst = 1'b1;
    req_valid = '0;
    req_x = '0;
    resp_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request from requester 2 with x=5.
    issue(2, 16'd5);
    drain(100, "single_drain");

    // Pointer now 3: requests 1 and 3 together, 3 first then wrap to 1.
    issue(1, XW'($urandom));
    issue(3, XW'($urandom));
    drain(200, "rr_wrap_drain");

    // All four pending after reset, plus a second job for 0.
    apply_reset();
    for (int i = 0; i < int'(NREQ); i++) issue(unsigned'(i), XW'($urandom));
    issue(0, XW'($urandom));
    drain(400, "all4_drain");

    // Engine never acknowledges start: watchdog error response.
    eng_dead = 1'b1;
    issue(1, XW'($urandom));
    drain(100, "watchdog_drain");
    eng_dead = 1'b0;

    // Response backpressure for 5 cycles with another request waiting.
    stall = 5;
    issue(0, XW'($urandom));
    issue(2, XW'($urandom));
    drain(200, "stall_drain");

    // Reset during WAIT_DONE drops the job.
    issue(1, 16'h1234);
    n = 0;
    while (!(busy && !eng_done) && n < 50) begin step(); n++; end
    chk("reach_wait_done", 64'(busy && !eng_done), 64'(1));
    repeat (3) step();
    #2;
    rst = 1'b1;
    #1;
    check_outputs_zero("midjob_rst");
    req_valid = '0;
    job_q.delete();
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (20) step();
    issue(2, XW'($urandom));
    issue(1, XW'($urandom));
    drain(200, "post_rst_drain");

    // Random traffic with occasional backpressure.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 5) == 0 && stall == 0) stall = $urandom_range(1, 4);
      issue($urandom_range(0, NREQ - 1), XW'($urandom));
      repeat ($urandom_range(0, 12)) step();
    end
    drain(5000, "random_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
